// File: rtl/wb_trace_pkg.sv
// Shared types for the write-back trace buffer.
//   trace_state_e : capture FSM encoding, visible on the top-level 'state' port.
//   trace_entry_t : one recorded write-back {pc, addr, data} at the default
//                   widths. The RAM stores the same field order as a flat
//                   vector, so entries can be unpacked with this type.
package wb_trace_pkg;

  localparam int TRACE_DATA_W = 32;
  localparam int TRACE_ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } trace_state_e;

  typedef struct packed {
    logic [TRACE_DATA_W-1:0] pc;
    logic [TRACE_ADDR_W-1:0] addr;
    logic [TRACE_DATA_W-1:0] data;
  } trace_entry_t;

endpackage

// File: rtl/trace_ram.sv
// Trace storage: DEPTH x WIDTH array, one write port, one registered read port.
//   clk, rst      : clock; rst clears only the read register, never the array
//   we/waddr/wdata: write port
//   re/raddr      : read request; rdata updates on the next edge
//   rdata         : registered read data, holds its value when re=0
module trace_ram #(
  parameter int WIDTH = 69,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/wb_trace_buffer.sv
// Register-file write-back trace buffer.
// Records {pc, addr, data} of every non-x0 write-back, starting with the write
// whose PC equals trig_pc, and lets software pop the entries oldest first.
//   clk, rst                 : clock, synchronous active-high reset
//   wb_en/wb_addr/wb_data/wb_pc : write-back being observed
//   arm, trig_pc, wrap_mode  : capture control (wrap_mode latched on entry to ARMED)
//   rd_en                    : pop request
//   rd_valid, rd_pc/addr/data: popped entry
//   count, overflow, state   : status and FSM state
//
// Read handshake: rd_en is a one-cycle pop request with no ready. It is acted
// on only in DONE with count>0 and no rising arm edge in the same cycle; an
// accepted pop raises rd_valid for exactly the next cycle with rd_* carrying
// the entry. Refused pops leave rd_valid low and rd_* unchanged.
module wb_trace_buffer
  import wb_trace_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wb_en,
  input  logic [ADDR_W-1:0]          wb_addr,
  input  logic [DATA_W-1:0]          wb_data,
  input  logic [DATA_W-1:0]          wb_pc,
  input  logic                       arm,
  input  logic [DATA_W-1:0]          trig_pc,
  input  logic                       wrap_mode,
  input  logic                       rd_en,
  output logic                       rd_valid,
  output logic [DATA_W-1:0]          rd_pc,
  output logic [ADDR_W-1:0]          rd_addr,
  output logic [DATA_W-1:0]          rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [1:0]                 state
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 2 * DATA_W + ADDR_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  trace_state_e     state_q;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;
  logic             wrap_q;
  logic             arm_q;
  logic             rd_valid_q;

  logic             arm_rise;
  logic             full;
  logic             trig_hit;
  logic             do_store;
  logic             rd_fire;
  logic [ENTRY_W-1:0] ram_rdata;

  always_comb begin
    arm_rise = arm & ~arm_q;
    full     = (count_q == FULL_CNT);
    trig_hit = wb_en && (wb_pc == trig_pc);
    do_store = 1'b0;
    rd_fire  = 1'b0;
    case (state_q)
      // The trigger write starts capture even if it targets x0, but like any
      // x0 write it is not recorded.
      ST_ARMED:   do_store = arm && trig_hit && (wb_addr != '0);
      ST_CAPTURE: do_store = arm && wb_en && (wb_addr != '0);
      // A rising arm edge restarts capture and wins over a pop.
      ST_DONE:    rd_fire  = rd_en && (count_q != '0) && !arm_rise;
      default:    ;
    endcase
    if (rst) begin
      do_store = 1'b0;
      rd_fire  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      wrap_q     <= 1'b0;
      arm_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      arm_q      <= arm;
      rd_valid_q <= rd_fire;

      // Storing into a full circular buffer drops the oldest entry, so the
      // read pointer moves with the write pointer and count stays at DEPTH.
      if (do_store) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        if (full) begin
          rd_ptr     <= rd_ptr + PTR_W'(1);
          overflow_q <= 1'b1;
        end else begin
          count_q <= count_q + CNT_W'(1);
        end
      end

      if (rd_fire) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        count_q <= count_q - CNT_W'(1);
      end

      case (state_q)
        ST_IDLE: begin
          if (arm) begin
            state_q    <= ST_ARMED;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            wrap_q     <= wrap_mode;
          end
        end
        ST_ARMED: begin
          if (!arm) begin
            state_q <= ST_IDLE;
          end else if (trig_hit) begin
            state_q <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (!arm) begin
            state_q <= ST_DONE;
          end else if (do_store && !wrap_q && (count_q == FULL_CNT - CNT_W'(1))) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (arm_rise) begin
            state_q    <= ST_ARMED;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            wrap_q     <= wrap_mode;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  trace_ram #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (do_store),
    .waddr (wr_ptr),
    .wdata ({wb_pc, wb_addr, wb_data}),
    .re    (rd_fire),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  assign rd_valid = rd_valid_q;
  assign rd_pc    = ram_rdata[ENTRY_W-1 -: DATA_W];
  assign rd_addr  = ram_rdata[DATA_W +: ADDR_W];
  assign rd_data  = ram_rdata[DATA_W-1:0];
  assign count    = count_q;
  assign overflow = overflow_q;
  assign state    = state_q;

endmodule
